stoch_mean_multi: RTL and testbench
===================================

Name: stoch_mean_multi

Overview:
Multi-channel estimator of the mean of stochastic bitstreams, with a parameterised channel count and output width. Two modes, selected at run time:
- Block-window mode: counts ones over a run-time-programmable window and latches the totals.
- Exponential-moving-average (EMA) mode: tracks a running mean continuously.
It sits after the stochastic neuron/HHMM datapaths and feeds their probability estimates back to binary logic. All channels share one window counter.

Parameters:
CH, 4, number of independent stochastic input channels
N, 8, accumulator/output width per channel; also window-length width
SHIFT, 4, EMA decay shift (alpha = 2^-SHIFT); 1 <= SHIFT <= 8

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high; clears all state
INIT  in  1  synchronous load: out/EMA accumulators <- START, window restarts
ENABLE  in  1  qualifies a sample cycle; when low all state holds
mode  in  1  0 = block window, 1 = EMA; sampled only at INIT or window end
win_len  in  N  window length in enabled cycles; 0 is treated as 1
in  in  CH  one stochastic bit per channel (bit c = channel c)
START  in  CH*N  initial output per channel (slice c = [c*N +: N])
out  out  CH*N  latched mean per channel (count of ones in block mode; EMA estimate scaled to N bits)
out_valid  out  1  one-cycle pulse when out has been updated
win_pos  out  N  current position in the window, 0..win_len-1

Behaviour:
- RESET asserted:
  - out, sum[c], ema[c], win_pos, out_valid and mode_r all go to 0 immediately.
  - Held state is kept until RESET is released.
- Priority per edge, highest first: RESET > INIT > !ENABLE (hold) > normal update.
- INIT:
  - out[c] <- START[c].
  - ema[c] <- {START[c], SHIFT zeros}.
  - sum[c] <- 0; win_pos <- 0; out_valid <- 0.
  - mode_r <- mode.
- Window counter (both modes), on each enabled cycle:
  - terminal = (win_pos >= eff_len-1), where eff_len = max(win_len, 1).
  - If terminal: win_pos <- 0. Otherwise win_pos <- win_pos + 1.
  - The >= compare makes a mid-window shrink of win_len end the current window on the next enabled cycle.
  - A grow just extends the current window.
- Block mode (mode_r = 0), per enabled cycle:
  - Not terminal: sum[c] <- sum[c] + in[c].
  - Terminal:
    - out[c] <- sum[c] + in[c], so the final sample is included.
    - sum[c] <- 0.
    - out_valid <- 1 for exactly one cycle.
  - Maximum count is eff_len <= 2^N-1, so sum never overflows. No saturation logic is required, but add an assertion.
  - Latency: out is visible the cycle after the terminal edge, together with out_valid.
- EMA mode (mode_r = 1):
  - Each channel holds an (N+SHIFT)-bit accumulator ema[c].
  - Each enabled cycle: ema[c] <- ema[c] - (ema[c] >> SHIFT) + (in[c] ? 2^N-1 : 0) << 0. The increment is (2^N - 1) zero-extended.
  - Result is unsigned and bounded by (2^N-1)*2^SHIFT, so it never wraps.
  - out[c] <- upper N bits of the next ema[c], updated every enabled cycle.
  - out_valid pulses only on terminal cycles, so consumers sample at the window rate.
- Mode switch:
  - mode is latched into mode_r only at INIT or on a terminal cycle.
  - On a terminal-cycle switch 0->1: ema[c] <- {sum[c]+in[c] scaled, i.e. out value just latched, SHIFT zeros}.
  - On a terminal-cycle switch 1->0: sum[c] <- 0.
- ENABLE low: all registers hold; out_valid is forced to 0.
- Channels are fully independent. Cross-channel interaction is a bug.

Test Plan:
- Block, N=8, win_len=10, in[0]=1 for 7 of 10 enabled cycles, in[1]=0, in[2..3]=1 constant -> out = {10,10,0,7}. out_valid high one cycle after the 10th sample; next window restarts from 0.
- ENABLE toggled 50% during a win_len=4 window, in=all ones -> terminal only after 4 enabled cycles, out[c]=4. out_valid never high while ENABLE=0.
- RESET asserted mid-window (win_pos=5, out=0x33) asynchronously between edges -> out, win_pos, out_valid read 0 before the next edge. After release, the first window counts from 0.
- INIT with START={8'h80,8'h40,8'h20,8'h10} in EMA mode, SHIFT=4, in=0 -> out[3] decays 0x80 -> 0x78 -> 0x70 (integer truncation), monotonic toward 0. With in=1 it converges toward 0xFF and never exceeds it.
- win_len changed 20 -> 3 while win_pos=7 -> window terminates on the next enabled cycle with out = sum+in. The next window lasts 3 enabled cycles.
- win_len=0 -> treated as 1: out_valid on every enabled cycle, out[c] = in[c] of that cycle. Mode switched 0->1 on a terminal cycle, then EMA seeded from the latched out value.

Source files
------------

// File: rtl/stoch_mean_multi.sv
// stoch_mean_multi: per-channel mean of stochastic bitstreams, block-window count or EMA.
// Latency: out/out_valid are registered and visible the cycle after the sampling edge.
// Backpressure: none; ENABLE low freezes all state and suppresses out_valid.
module stoch_mean_multi #(
    parameter int CH    = 4,
    parameter int N     = 8,
    parameter int SHIFT = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            INIT,
    input  logic            ENABLE,
    input  logic            mode,
    input  logic [N-1:0]    win_len,
    input  logic [CH-1:0]   in,
    input  logic [CH*N-1:0] START,
    output logic [CH*N-1:0] out,
    output logic            out_valid,
    output logic [N-1:0]    win_pos
);
    localparam int EW = N + SHIFT;
    // Full-scale sample contribution and the largest value an EMA accumulator can reach.
    localparam logic [EW-1:0] INC_ONE = {{SHIFT{1'b0}}, {N{1'b1}}};
    localparam logic [EW-1:0] EMA_MAX = {{N{1'b1}}, {SHIFT{1'b0}}};

    logic [N-1:0]  sum [CH];
    logic [EW-1:0] ema [CH];
    logic          mode_r;

    logic [N-1:0]  last_pos;
    logic          terminal;
    logic [N:0]    blk_total [CH];
    logic [EW-1:0] ema_next  [CH];

    // Last position of the window (zero length behaves as one); >= lets a shrink end the window early.
    always_comb begin
        last_pos = (win_len == '0) ? '0 : win_len - 1'b1;
        terminal = (win_pos >= last_pos);
    end

    // Per-channel candidates: block total including this sample, and the next EMA value.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            blk_total[c] = {1'b0, sum[c]} + {{N{1'b0}}, in[c]};
            ema_next[c]  = ema[c] - (ema[c] >> SHIFT) + (in[c] ? INC_ONE : '0);
        end
    end

    // Window counter, per-channel accumulators, output latch and mode latch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out       <= '0;
            out_valid <= 1'b0;
            win_pos   <= '0;
            mode_r    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                sum[c] <= '0;
                ema[c] <= '0;
            end
        end else if (INIT) begin
            out       <= START;
            out_valid <= 1'b0;
            win_pos   <= '0;
            mode_r    <= mode;
            for (int c = 0; c < CH; c++) begin
                sum[c] <= '0;
                ema[c] <= {START[c*N +: N], {SHIFT{1'b0}}};
            end
        end else if (!ENABLE) begin
            out_valid <= 1'b0;
        end else begin
            win_pos   <= terminal ? '0 : win_pos + 1'b1;
            out_valid <= terminal;
            if (!mode_r) begin
                for (int c = 0; c < CH; c++) begin
                    if (terminal) begin
                        out[c*N +: N] <= blk_total[c][N-1:0];
                        sum[c]        <= '0;
                        // Entering EMA: seed from the count just latched.
                        if (mode) begin
                            ema[c] <= {blk_total[c][N-1:0], {SHIFT{1'b0}}};
                        end
                    end else begin
                        sum[c] <= blk_total[c][N-1:0];
                    end
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    ema[c]        <= ema_next[c];
                    out[c*N +: N] <= ema_next[c][EW-1:SHIFT];
                    if (terminal) begin
                        sum[c] <= '0;
                    end
                end
            end
            if (terminal) begin
                mode_r <= mode;
            end
        end
    end

    // Window length is at most 2^N-1 so the count fits; EMA stays within full scale.
    for (genvar g = 0; g < CH; g++) begin : g_chk
        assert property (@(posedge CLK) disable iff (RESET)
            (ENABLE && !INIT && !mode_r) |-> !blk_total[g][N]);
        assert property (@(posedge CLK) disable iff (RESET)
            ema[g] <= EMA_MAX);
    end

endmodule

// File: tb/tb_stoch_mean_multi.sv
// tb_stoch_mean_multi: directed table, hand sequences, and random run against a reference model.
// Latency: outputs checked #1 after each rising edge.
// Backpressure: not applicable.
module tb_stoch_mean_multi;
    localparam int CH = 4;
    localparam int N = 8;
    localparam int SHIFT = 4;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            INIT;
    logic            ENABLE;
    logic            mode;
    logic [N-1:0]    win_len;
    logic [CH-1:0]   in;
    logic [CH*N-1:0] START;
    logic [CH*N-1:0] out;
    logic            out_valid;
    logic [N-1:0]    win_pos;

    stoch_mean_multi #(.CH(CH), .N(N), .SHIFT(SHIFT)) dut (
        .CLK(CLK), .RESET(RESET), .INIT(INIT), .ENABLE(ENABLE), .mode(mode),
        .win_len(win_len), .in(in), .START(START),
        .out(out), .out_valid(out_valid), .win_pos(win_pos)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [7:0]  wl;
        logic [3:0]  din;
        logic        exp_vld;
        logic [7:0]  exp_pos;
        logic [31:0] exp_out;
    } vec_t;

    vec_t tbl [12];

    // Reference model state: plain integers following the behavioural rules.
    int m_out [CH];
    int m_sum [CH];
    int m_ema [CH];
    int m_pos;
    bit m_mode;
    bit m_vld;

    task automatic model_edge();
        int eff;
        bit term;
        if (INIT) begin
            for (int c = 0; c < CH; c++) begin
                m_out[c] = int'(START[c*N +: N]);
                m_ema[c] = m_out[c] * (1 << SHIFT);
                m_sum[c] = 0;
            end
            m_pos = 0; m_vld = 0; m_mode = mode;
        end else if (!ENABLE) begin
            m_vld = 0;
        end else begin
            eff  = (win_len == 0) ? 1 : int'(win_len);
            term = (m_pos >= eff - 1);
            m_pos = term ? 0 : m_pos + 1;
            m_vld = term;
            for (int c = 0; c < CH; c++) begin
                if (!m_mode) begin
                    if (term) begin
                        m_out[c] = m_sum[c] + int'(in[c]);
                        m_sum[c] = 0;
                        if (mode) m_ema[c] = m_out[c] * (1 << SHIFT);
                    end else begin
                        m_sum[c] = m_sum[c] + int'(in[c]);
                    end
                end else begin
                    m_ema[c] = m_ema[c] - m_ema[c] / (1 << SHIFT) + (in[c] ? 255 : 0);
                    m_out[c] = m_ema[c] / (1 << SHIFT);
                    if (term && !mode) m_sum[c] = 0;
                end
            end
            if (term) m_mode = mode;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp;
        int vcount;
        RESET = 1'b1; INIT = 1'b0; ENABLE = 1'b0; mode = 1'b0;
        win_len = '0; in = '0; START = '0;
        #12;
        check("reset_out", out, 32'h0);
        check("reset_pos", {24'h0, win_pos}, 32'h0);
        check("reset_vld", {31'h0, out_valid}, 32'h0);
        RESET = 1'b0;

        // Block window of 10 with a 7/10 channel.
        INIT = 1'b1; ENABLE = 1'b1; win_len = 8'd10; step(); INIT = 1'b0;
        check("blk_init_out", out, 32'h0);
        for (int k = 0; k < 10; k++) begin
            in = {3'b110, (k < 7)};
            step();
            if (k == 8) begin
                check("blk_pos9", {24'h0, win_pos}, 32'd9);
                check("blk_vld_early", {31'h0, out_valid}, 32'h0);
            end
        end
        check("blk_vld", {31'h0, out_valid}, 32'h1);
        check("blk_out", out, 32'h0A0A0007);
        check("blk_pos_wrap", {24'h0, win_pos}, 32'h0);
        in = '0; step();
        check("blk_vld_pulse", {31'h0, out_valid}, 32'h0);
        check("blk_restart_pos", {24'h0, win_pos}, 32'd1);

        // Table: ENABLE gating on a 4-window, then zero-length windows.
        for (int i = 0; i < 8; i++) begin
            tbl[i].en = (i % 2 == 0); tbl[i].wl = 8'd4; tbl[i].din = 4'hF;
            tbl[i].exp_vld = (i == 6);
            tbl[i].exp_pos = (i >= 6) ? 8'd0 : 8'((i / 2) + 1);
            tbl[i].exp_out = (i >= 6) ? 32'h04040404 : 32'h0;
        end
        tbl[8]  = '{1'b1, 8'd0, 4'h5, 1'b1, 8'd0, 32'h00010001};
        tbl[9]  = '{1'b1, 8'd0, 4'hA, 1'b1, 8'd0, 32'h01000100};
        tbl[10] = '{1'b0, 8'd0, 4'hF, 1'b0, 8'd0, 32'h01000100};
        tbl[11] = '{1'b1, 8'd0, 4'hF, 1'b1, 8'd0, 32'h01010101};
        INIT = 1'b1; ENABLE = 1'b1; mode = 1'b0; win_len = 8'd4; step(); INIT = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ENABLE = tbl[i].en; win_len = tbl[i].wl; in = tbl[i].din;
            step();
            check($sformatf("tbl%0d_vld", i), {31'h0, out_valid}, {31'h0, tbl[i].exp_vld});
            check($sformatf("tbl%0d_pos", i), {24'h0, win_pos}, {24'h0, tbl[i].exp_pos});
            check($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
        end

        // Asynchronous reset mid-window.
        ENABLE = 1'b1; INIT = 1'b1; START = 32'h33333333; win_len = 8'd20; in = '0;
        step(); INIT = 1'b0;
        check("rst_pre_out", out, 32'h33333333);
        repeat (5) step();
        check("rst_pre_pos", {24'h0, win_pos}, 32'd5);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_out", out, 32'h0);
        check("rst_async_pos", {24'h0, win_pos}, 32'h0);
        check("rst_async_vld", {31'h0, out_valid}, 32'h0);
        #2 RESET = 1'b0;
        win_len = 8'd3; in = 4'hF;
        step();
        check("rst_after_pos", {24'h0, win_pos}, 32'd1);
        step(); step();
        check("rst_after_vld", {31'h0, out_valid}, 32'h1);
        check("rst_after_out", out, 32'h03030303);

        // EMA decay from START, then convergence to full scale.
        INIT = 1'b1; mode = 1'b1; START = 32'h80402010; win_len = 8'd5; in = '0;
        step(); INIT = 1'b0;
        check("ema_init_out", out, 32'h80402010);
        step();
        check("ema_decay1", out, 32'h783C1E0F);
        step();
        check("ema_decay2", out, 32'h70381C0E);
        in = 4'hF; vcount = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (out_valid) vcount++;
        end
        check("ema_converge", out, 32'hFFFFFFFF);
        check("ema_vld_rate", vcount, 32'd60);

        // Mid-window shrink 20 -> 3.
        INIT = 1'b1; mode = 1'b0; START = '0; win_len = 8'd20; in = 4'hF;
        step(); INIT = 1'b0;
        repeat (7) step();
        check("shrink_pos7", {24'h0, win_pos}, 32'd7);
        win_len = 8'd3; step();
        check("shrink_vld", {31'h0, out_valid}, 32'h1);
        check("shrink_out", out, 32'h08080808);
        check("shrink_pos", {24'h0, win_pos}, 32'h0);
        step(); step();
        check("shrink_next_pos", {24'h0, win_pos}, 32'd2);
        check("shrink_next_vld", {31'h0, out_valid}, 32'h0);
        step();
        check("shrink_next_out", out, 32'h03030303);

        // Mode switches on zero-length windows.
        win_len = 8'd0; mode = 1'b1; in = 4'b0011; step();
        check("sw01_out", out, 32'h00000101);
        in = 4'b0001; step();
        check("sw01_ema_out", out, 32'h00000010);
        check("sw01_ema_vld", {31'h0, out_valid}, 32'h1);
        mode = 1'b0; in = 4'b0000; step();
        check("sw10_ema_out", out, 32'h0000000F);
        in = 4'b1000; step();
        check("sw10_blk_out", out, 32'h01000000);

        // Randomised run against the reference model.
        for (int i = 0; i < 2000; i++) begin
            INIT   = (i == 0) || ($urandom_range(0, 99) == 0);
            ENABLE = ($urandom_range(0, 3) != 0);
            in     = 4'($urandom_range(0, 15));
            START  = $urandom;
            if ($urandom_range(0, 19) == 0) win_len = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            @(posedge CLK);
            model_edge();
            #1;
            for (int c = 0; c < CH; c++) exp[c*N +: N] = 8'(m_out[c]);
            check($sformatf("rnd%0d_out", i), out, exp);
            check($sformatf("rnd%0d_vld", i), {31'h0, out_valid}, {31'h0, m_vld});
            check($sformatf("rnd%0d_pos", i), {24'h0, win_pos}, 32'(m_pos));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
